// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the 8-bit SPI master.
//   MODE0..MODE3 : {CPOL, CPHA} mode encodings
//   SPI_W        : transfer width in bits
//   spi_state_t  : master FSM state encoding
package spi_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int SPI_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_DONE
    } spi_state_t;

endpackage

// File: rtl/spi_clk_tick.sv
// spi_clk_tick: half-period timer for the SPI master.
// Produces a one-cycle tick on every CLK_DIV-th enabled cycle.
//   CLK    : system clock
//   reset  : synchronous active-high reset
//   enable : count this cycle
//   clear  : force the counter back to zero
//   tick   : high in the cycle that completes a half-period
module spi_clk_tick
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int              CW   = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("spi_clk_tick: CLK_DIV must be >= 1");
        end
    endgenerate

    logic [CW-1:0] count;

    // Combinational so the FSM acts in the very cycle the period completes.
    assign tick = enable && (count == LAST);

    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: single-transfer 8-bit SPI master, MSB first, any CPOL/CPHA mode.
//   CLK     : system clock (rising edge)
//   reset   : synchronous active-high reset
//   start   : request a transfer, honoured only in IDLE
//   data_in : byte to send, latched when start is accepted
//   MISO    : serial data from the slave
//   SCLK    : serial clock, idles at CPOL
//   MOSI    : serial data to the slave
//   CS      : active-low chip select
//   busy    : transfer in progress
//   done    : one-cycle pulse when the received byte is presented
//   rx      : last received byte, held until the next done
module spi_master
    import spi_pkg::*;
#(
    parameter logic [1:0] MODE    = MODE2,
    parameter int         CLK_DIV = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [SPI_W-1:0] data_in,
    input  logic             MISO,
    output logic             SCLK,
    output logic             MOSI,
    output logic             CS,
    output logic             busy,
    output logic             done,
    output logic [SPI_W-1:0] rx
);

    localparam logic CPOL = MODE[1];
    localparam logic CPHA = MODE[0];

    generate
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("spi_master: CLK_DIV must be >= 1");
        end
    endgenerate

    spi_state_t       state;
    logic [SPI_W-1:0] tx_shift;
    logic [SPI_W-1:0] rx_shift;
    logic [SPI_W-1:0] rx_next;
    logic [3:0]       edge_cnt;
    logic             tick;
    logic             tick_en;
    logic             tick_clr;
    logic             leading;

    assign tick_en  = (state == ST_SETUP) || (state == ST_XFER) || (state == ST_HOLD);
    assign tick_clr = (state == ST_IDLE) || (state == ST_DONE);

    // edge_cnt holds the number of toggles already made, so the upcoming
    // toggle k = edge_cnt + 1 is a leading edge when edge_cnt is even.
    assign leading = ~edge_cnt[0];
    assign rx_next = {rx_shift[SPI_W-2:0], MISO};

    spi_clk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .CLK    (CLK),
        .reset  (reset),
        .enable (tick_en),
        .clear  (tick_clr),
        .tick   (tick)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= ST_IDLE;
            SCLK     <= CPOL;
            CS       <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx       <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            edge_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    CS       <= 1'b1;
                    SCLK     <= CPOL;
                    busy     <= 1'b0;
                    edge_cnt <= '0;
                    if (start) begin
                        state    <= ST_SETUP;
                        CS       <= 1'b0;
                        busy     <= 1'b1;
                        rx_shift <= '0;
                        // CPHA=0 needs bit 7 on the wire before the first
                        // (sampling) edge, so it goes out now and only the
                        // remaining bits stay in the shifter.
                        if (!CPHA) begin
                            MOSI     <= data_in[SPI_W-1];
                            tx_shift <= {data_in[SPI_W-2:0], 1'b0};
                        end else begin
                            tx_shift <= data_in;
                        end
                    end
                end

                ST_SETUP: begin
                    if (tick) begin
                        state <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (tick) begin
                        SCLK     <= ~SCLK;
                        edge_cnt <= edge_cnt + 4'd1;
                        // Sample edges are leading for CPHA=0, trailing for
                        // CPHA=1; the other edge drives MOSI, except that
                        // CPHA=0 keeps bit 0 on the wire after the final edge.
                        if (leading == !CPHA) begin
                            rx_shift <= rx_next;
                        end else if (leading || (edge_cnt != 4'd15)) begin
                            MOSI     <= tx_shift[SPI_W-1];
                            tx_shift <= {tx_shift[SPI_W-2:0], 1'b0};
                        end
                        if (edge_cnt == 4'd15) begin
                            state <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (tick) begin
                        state <= ST_DONE;
                        CS    <= 1'b1;
                        MOSI  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        rx    <= rx_shift;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master.
// Five instances cover modes 0..3 at CLK_DIV=2 plus mode 2 at CLK_DIV=1.
// A per-instance slave model watches CS/SCLK, records the MOSI bit seen at
// every sample edge and serves MISO either from a byte pattern or in loopback.
module tb_spi_master;
    import spi_pkg::*;

    localparam int         N = 5;
    localparam logic [1:0] MODES [N] = '{MODE0, MODE1, MODE2, MODE3, MODE2};
    localparam int         DIVS  [N] = '{2, 2, 2, 2, 1};

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       reset_s [N];
    logic       start_s [N];
    logic [7:0] din_s   [N];
    logic       loop_a  [N];
    logic [7:0] pat_a   [N];

    logic [N-1:0] sclk_v, mosi_v, cs_v, busy_v, done_v;
    logic [7:0]   rx_a  [N];
    logic [7:0]   cap_a [N];
    int           unst_a [N];
    int           tog_a  [N];
    int           dcnt_a [N];

    int checks = 0;
    int passes = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic       miso     = 1'b0;
        logic       psclk    = 1'b0;
        logic       pmosi    = 1'b0;
        logic       pcs      = 1'b1;
        logic [7:0] cap      = 8'h00;
        int         toggles  = 0;
        int         samples  = 0;
        int         unstable = 0;
        int         dcnt     = 0;

        spi_master #(
            .MODE    (MODES[g]),
            .CLK_DIV (DIVS[g])
        ) u_dut (
            .CLK     (CLK),
            .reset   (reset_s[g]),
            .start   (start_s[g]),
            .data_in (din_s[g]),
            .MISO    (miso),
            .SCLK    (sclk_v[g]),
            .MOSI    (mosi_v[g]),
            .CS      (cs_v[g]),
            .busy    (busy_v[g]),
            .done    (done_v[g]),
            .rx      (rx_a[g])
        );

        // Slave model: the n-th sample edge sees MISO bit 7-n and captures MOSI.
        always @(negedge CLK) begin
            if (done_v[g] === 1'b1) dcnt++;
            if (pcs === 1'b1 && cs_v[g] === 1'b0) begin
                toggles  = 0;
                samples  = 0;
                unstable = 0;
                cap      = 8'h00;
            end else if (cs_v[g] === 1'b0 && sclk_v[g] !== psclk) begin
                toggles++;
                if (((toggles % 2) == 1) == (MODES[g][0] == 1'b0)) begin
                    if (samples < 8) cap[7 - samples] = pmosi;
                    if (mosi_v[g] !== pmosi) unstable++;
                    samples++;
                end
            end
            if (loop_a[g]) miso = mosi_v[g];
            else if (samples < 8) miso = pat_a[g][7 - samples];
            else miso = 1'b0;
            psclk = sclk_v[g];
            pmosi = mosi_v[g];
            pcs   = cs_v[g];
        end

        assign cap_a[g]  = cap;
        assign unst_a[g] = unstable;
        assign tog_a[g]  = toggles;
        assign dcnt_a[g] = dcnt;
    end

    // Sample and drive just after the falling edge, after the slave model.
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    // Starts one transfer and returns the cycles from acceptance to done (-1 on timeout).
    task automatic do_transfer(input int g, input logic [7:0] d, output int lat);
        step();
        start_s[g] = 1'b1;
        din_s[g]   = d;
        step();
        start_s[g] = 1'b0;
        din_s[g]   = 8'($urandom);
        lat = 1;
        while (done_v[g] !== 1'b1 && lat < 400) begin
            step();
            lat++;
        end
        if (done_v[g] !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        for (int g = 0; g < N; g++) reset_s[g] = 1'b1;
        step();
        step();
        for (int g = 0; g < N; g++) begin
            logic cpol;
            cpol = MODES[g][1];
            checks++;
            if (cs_v[g] !== 1'b1) $display("[TB] FAIL reset_cs u%0d: got %b expected 1", g, cs_v[g]);
            else passes++;
            checks++;
            if (sclk_v[g] !== cpol) $display("[TB] FAIL reset_sclk u%0d: got %b expected %b", g, sclk_v[g], cpol);
            else passes++;
            checks++;
            if (mosi_v[g] !== 1'b0) $display("[TB] FAIL reset_mosi u%0d: got %b expected 0", g, mosi_v[g]);
            else passes++;
            checks++;
            if (busy_v[g] !== 1'b0) $display("[TB] FAIL reset_busy u%0d: got %b expected 0", g, busy_v[g]);
            else passes++;
            checks++;
            if (done_v[g] !== 1'b0) $display("[TB] FAIL reset_done u%0d: got %b expected 0", g, done_v[g]);
            else passes++;
            checks++;
            if (rx_a[g] !== 8'h00) $display("[TB] FAIL reset_rx u%0d: got %h expected 00", g, rx_a[g]);
            else passes++;
        end
        for (int g = 0; g < N; g++) reset_s[g] = 1'b0;
        step();
    endtask

    // Mode 2 against a pattern-driven slave: fixed B3/CA case, then random bytes.
    task automatic test_mode2_pattern();
        int         lat;
        logic [7:0] d, p;
        loop_a[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 8'hB3 : 8'($urandom);
            p = (i == 0) ? 8'hCA : 8'($urandom);
            pat_a[2] = p;
            checks++;
            if (sclk_v[2] !== 1'b1) $display("[TB] FAIL m2_idle_sclk: got %b expected 1", sclk_v[2]);
            else passes++;
            do_transfer(2, d, lat);
            checks++;
            if (lat != 1 + 18 * DIVS[2]) $display("[TB] FAIL m2_latency: got %0d expected %0d", lat, 1 + 18 * DIVS[2]);
            else passes++;
            checks++;
            if (rx_a[2] !== p) $display("[TB] FAIL m2_rx: got %h expected %h", rx_a[2], p);
            else passes++;
            checks++;
            if (cap_a[2] !== d) $display("[TB] FAIL m2_mosi_bits: got %h expected %h", cap_a[2], d);
            else passes++;
            checks++;
            if (cs_v[2] !== 1'b1 || sclk_v[2] !== 1'b1 || mosi_v[2] !== 1'b0)
                $display("[TB] FAIL m2_end_lines: got cs=%b sclk=%b mosi=%b expected cs=1 sclk=1 mosi=0",
                         cs_v[2], sclk_v[2], mosi_v[2]);
            else passes++;
        end
    endtask

    // Loopback in every mode: the received byte must equal the transmitted one.
    task automatic test_loopback_modes();
        int         lat;
        logic [7:0] d;
        logic       cpol;
        for (int g = 0; g < 4; g++) begin
            loop_a[g] = 1'b1;
            cpol = MODES[g][1];
            for (int i = 0; i < 3; i++) begin
                d = (i == 0) ? 8'h5A : 8'($urandom);
                checks++;
                if (sclk_v[g] !== cpol) $display("[TB] FAIL lb_idle_sclk u%0d: got %b expected %b", g, sclk_v[g], cpol);
                else passes++;
                do_transfer(g, d, lat);
                checks++;
                if (lat != 1 + 18 * DIVS[g]) $display("[TB] FAIL lb_latency u%0d: got %0d expected %0d", g, lat, 1 + 18 * DIVS[g]);
                else passes++;
                checks++;
                if (rx_a[g] !== d) $display("[TB] FAIL lb_rx u%0d: got %h expected %h", g, rx_a[g], d);
                else passes++;
                checks++;
                if (cap_a[g] !== d) $display("[TB] FAIL lb_mosi_bits u%0d: got %h expected %h", g, cap_a[g], d);
                else passes++;
                checks++;
                if (unst_a[g] != 0) $display("[TB] FAIL lb_mosi_stable u%0d: got %0d unstable samples expected 0", g, unst_a[g]);
                else passes++;
                checks++;
                if (sclk_v[g] !== cpol) $display("[TB] FAIL lb_end_sclk u%0d: got %b expected %b", g, sclk_v[g], cpol);
                else passes++;
            end
        end
    endtask

    // A second start during XFER must change nothing.
    task automatic test_ignore_start();
        int         n, d0;
        logic [7:0] d, p;
        d = 8'($urandom);
        p = 8'($urandom);
        loop_a[2] = 1'b0;
        pat_a[2]  = p;
        d0 = dcnt_a[2];
        step();
        start_s[2] = 1'b1;
        din_s[2]   = d;
        step();
        start_s[2] = 1'b0;
        n = 1;
        while (tog_a[2] < 3 && n < 200) begin
            step();
            n++;
        end
        start_s[2] = 1'b1;
        din_s[2]   = 8'hFF;
        step();
        n++;
        start_s[2] = 1'b0;
        while (done_v[2] !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (n != 1 + 18 * DIVS[2]) $display("[TB] FAIL ign_latency: got %0d expected %0d", n, 1 + 18 * DIVS[2]);
        else passes++;
        checks++;
        if (rx_a[2] !== p) $display("[TB] FAIL ign_rx: got %h expected %h", rx_a[2], p);
        else passes++;
        checks++;
        if (cap_a[2] !== d) $display("[TB] FAIL ign_mosi_bits: got %h expected %h", cap_a[2], d);
        else passes++;
        repeat (60) step();
        checks++;
        if (dcnt_a[2] - d0 != 1) $display("[TB] FAIL ign_done_count: got %0d expected 1", dcnt_a[2] - d0);
        else passes++;
    endtask

    // Reset at toggle 7 aborts silently; the next transfer still works.
    task automatic test_reset_mid();
        int         n, d0, lat;
        logic [7:0] d;
        loop_a[3] = 1'b1;
        d = 8'($urandom);
        step();
        start_s[3] = 1'b1;
        din_s[3]   = d;
        step();
        start_s[3] = 1'b0;
        n = 1;
        while (tog_a[3] < 7 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (tog_a[3] != 7) $display("[TB] FAIL rst_reach_k7: got %0d toggles expected 7", tog_a[3]);
        else passes++;
        reset_s[3] = 1'b1;
        step();
        checks++;
        if (cs_v[3] !== 1'b1 || sclk_v[3] !== 1'b1 || busy_v[3] !== 1'b0 || done_v[3] !== 1'b0 || mosi_v[3] !== 1'b0)
            $display("[TB] FAIL rst_mid_lines: got cs=%b sclk=%b busy=%b done=%b mosi=%b expected 1 1 0 0 0",
                     cs_v[3], sclk_v[3], busy_v[3], done_v[3], mosi_v[3]);
        else passes++;
        checks++;
        if (rx_a[3] !== 8'h00) $display("[TB] FAIL rst_mid_rx: got %h expected 00", rx_a[3]);
        else passes++;
        reset_s[3] = 1'b0;
        d0 = dcnt_a[3];
        repeat (60) step();
        checks++;
        if (dcnt_a[3] != d0) $display("[TB] FAIL rst_no_done: got %0d pulses expected 0", dcnt_a[3] - d0);
        else passes++;
        d = 8'($urandom);
        do_transfer(3, d, lat);
        checks++;
        if (lat != 1 + 18 * DIVS[3]) $display("[TB] FAIL rst_after_latency: got %0d expected %0d", lat, 1 + 18 * DIVS[3]);
        else passes++;
        checks++;
        if (rx_a[3] !== d) $display("[TB] FAIL rst_after_rx: got %h expected %h", rx_a[3], d);
        else passes++;
    endtask

    // start held high at CLK_DIV=1: repeated transfers with a 2-cycle CS gap.
    task automatic test_back_to_back();
        int         c, fall_c, high_run, ndone;
        logic       prev_cs, first;
        logic [7:0] cur;
        loop_a[4] = 1'b1;
        cur = 8'($urandom);
        step();
        start_s[4] = 1'b1;
        din_s[4]   = cur;
        c = 0; fall_c = 0; high_run = 0; ndone = 0;
        prev_cs = 1'b1;
        first   = 1'b1;
        while (ndone < 3 && c < 300) begin
            step();
            c++;
            if (cs_v[4] === 1'b0 && prev_cs === 1'b1) begin
                if (!first) begin
                    checks++;
                    if (high_run != 2) $display("[TB] FAIL b2b_cs_gap: got %0d cycles expected 2", high_run);
                    else passes++;
                end
                first  = 1'b0;
                fall_c = c;
            end
            if (cs_v[4] === 1'b1) high_run++;
            else high_run = 0;
            if (done_v[4] === 1'b1) begin
                checks++;
                if (c - fall_c + 1 != 1 + 18 * DIVS[4])
                    $display("[TB] FAIL b2b_latency: got %0d expected %0d", c - fall_c + 1, 1 + 18 * DIVS[4]);
                else passes++;
                checks++;
                if (rx_a[4] !== cur) $display("[TB] FAIL b2b_rx: got %h expected %h", rx_a[4], cur);
                else passes++;
                ndone++;
                cur       = 8'($urandom);
                din_s[4]  = cur;
            end
            prev_cs = cs_v[4];
        end
        start_s[4] = 1'b0;
        checks++;
        if (ndone != 3) $display("[TB] FAIL b2b_done_count: got %0d expected 3", ndone);
        else passes++;
        repeat (5) step();
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            reset_s[g] = 1'b1;
            start_s[g] = 1'b0;
            din_s[g]   = 8'h00;
            loop_a[g]  = 1'b0;
            pat_a[g]   = 8'h00;
        end
        test_reset();
        test_mode2_pattern();
        test_loopback_modes();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
